// File: rtl/ysyx_22041412_axi_pkg.sv
// Shared AXI4 encodings and FSM state types for the dcache AXI master bridge.
package ysyx_22041412_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_8B = 3'b011;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2,
    R_HOLD = 2'd3
  } r_state_e;

  typedef enum logic [2:0] {
    W_IDLE = 3'd0,
    W_ADDR = 3'd1,
    W_DATA = 3'd2,
    W_RESP = 3'd3,
    W_HOLD = 3'd4
  } w_state_e;

  // EXOKAY counts as an error: the bridge never issues exclusive accesses.
  function automatic logic resp_err(input logic [1:0] resp);
    return (resp == RESP_EXOKAY) || (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/ysyx_22041412_dcache_axi_if.sv
// AXI4 bus between the dcache bridge (master) and the SoC crossbar (slave).
// Every channel transfers on the rising edge where valid and ready are both 1;
// valid never waits for ready, and payload is held stable while valid is high.
interface ysyx_22041412_dcache_axi_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [3:0]              arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  logic [3:0]              awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/ysyx_22041412_axi_wr_ch.sv
// Write channel of the dcache bridge: AW, then W beats counted against len, then B.
module ysyx_22041412_axi_wr_ch
  import ysyx_22041412_axi_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 64,
  parameter logic [3:0] ID         = 4'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_valid_i,
  input  logic [ADDR_WIDTH-1:0]   w_addr_i,
  input  logic [2:0]              w_size_i,
  input  logic [7:0]              w_len_i,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  output logic                    w_ready_o,
  output logic                    w_last_o,
  output w_state_e                state_o,
  output logic [3:0]              awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic                    bvalid,
  output logic                    bready
);
  w_state_e              state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [7:0]            cnt;
  logic                  last_q;
  logic                  at_last;

  assign at_last = (cnt == len_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= W_IDLE;
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
      cnt    <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_q <= (state == W_RESP) && bvalid;
      if (state == W_IDLE && w_valid_i) begin
        addr_q <= w_addr_i;
        len_q  <= w_len_i;
        size_q <= w_size_i;
        cnt    <= '0;
      end else if (state == W_DATA && wready && !at_last) begin
        // Stops at len so a 256-beat burst never wraps the 8-bit counter.
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      W_IDLE:  if (w_valid_i)         state_nxt = W_ADDR;
      W_ADDR:  if (awready)           state_nxt = W_DATA;
      W_DATA:  if (wready && at_last) state_nxt = W_RESP;
      W_RESP:  if (bvalid)            state_nxt = W_HOLD;
      W_HOLD:                         state_nxt = W_IDLE;
      default:                        state_nxt = W_IDLE;
    endcase
  end

  assign awid      = ID;
  assign awaddr    = addr_q;
  assign awlen     = len_q;
  assign awsize    = size_q;
  assign awburst   = AXI_BURST_INCR;
  assign awvalid   = (state == W_ADDR);
  assign wvalid    = (state == W_DATA);
  assign wdata     = w_data_i;
  assign wstrb     = '1;
  assign wlast     = wvalid && at_last;
  assign w_ready_o = wvalid && wready;
  assign bready    = (state == W_RESP);
  assign w_last_o  = last_q;
  assign state_o   = state;
endmodule

// File: rtl/ysyx_22041412_dcache_axi.sv
// Dcache-to-AXI4 master bridge; independent read and write FSMs, INCR bursts only.
// Define YSYX_22041412_AXI_ERR_CHK_EN to add sticky response-error reporting ports.
module ysyx_22041412_dcache_axi
  import ysyx_22041412_axi_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 64,
  parameter logic [3:0] ID         = 4'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_valid_i,
  input  logic [ADDR_WIDTH-1:0] r_addr_i,
  input  logic [7:0]            r_len_i,
  output logic                  r_ready_o,
  output logic                  r_last_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  input  logic                  w_valid_i,
  input  logic [ADDR_WIDTH-1:0] w_addr_i,
  input  logic [2:0]            w_size_i,
  input  logic [7:0]            w_len_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  output logic                  w_ready_o,
  output logic                  w_last_o,
`ifdef YSYX_22041412_AXI_ERR_CHK_EN
  output logic                  axi_err_o,
  output logic [ADDR_WIDTH-1:0] axi_err_addr_o,
`endif
  output r_state_e              r_state_o,
  output w_state_e              w_state_o,
  ysyx_22041412_dcache_axi_if.master axi
);
  r_state_e              r_state, r_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [7:0]            r_len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= R_IDLE;
      r_addr_q <= '0;
      r_len_q  <= '0;
    end else begin
      r_state <= r_state_nxt;
      if (r_state == R_IDLE && r_valid_i) begin
        r_addr_q <= r_addr_i;
        r_len_q  <= r_len_i;
      end
    end
  end

  // R_HOLD absorbs the cycle in which the cache is still dropping r_valid_i.
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (r_valid_i)                r_state_nxt = R_ADDR;
      R_ADDR:  if (axi.arready)              r_state_nxt = R_DATA;
      R_DATA:  if (axi.rvalid && axi.rlast)  r_state_nxt = R_HOLD;
      R_HOLD:                                r_state_nxt = R_IDLE;
      default:                               r_state_nxt = R_IDLE;
    endcase
  end

  assign axi.arid    = ID;
  assign axi.araddr  = r_addr_q;
  assign axi.arlen   = r_len_q;
  assign axi.arsize  = SIZE_8B;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = (r_state == R_ADDR);
  assign axi.rready  = (r_state == R_DATA);
  assign r_ready_o   = axi.rready && axi.rvalid;
  assign r_last_o    = r_ready_o && axi.rlast;
  assign r_data_o    = axi.rdata;
  assign r_state_o   = r_state;

  ysyx_22041412_axi_wr_ch #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ID        (ID)
  ) u_wr_ch (
    .clk      (clk),
    .rst      (rst),
    .w_valid_i(w_valid_i),
    .w_addr_i (w_addr_i),
    .w_size_i (w_size_i),
    .w_len_i  (w_len_i),
    .w_data_i (w_data_i),
    .w_ready_o(w_ready_o),
    .w_last_o (w_last_o),
    .state_o  (w_state_o),
    .awid     (axi.awid),
    .awaddr   (axi.awaddr),
    .awlen    (axi.awlen),
    .awsize   (axi.awsize),
    .awburst  (axi.awburst),
    .awvalid  (axi.awvalid),
    .awready  (axi.awready),
    .wdata    (axi.wdata),
    .wstrb    (axi.wstrb),
    .wlast    (axi.wlast),
    .wvalid   (axi.wvalid),
    .wready   (axi.wready),
    .bvalid   (axi.bvalid),
    .bready   (axi.bready)
  );

`ifdef YSYX_22041412_AXI_ERR_CHK_EN
  logic rd_err, wr_err;

  assign rd_err = r_ready_o && resp_err(axi.rresp);
  assign wr_err = axi.bvalid && axi.bready && resp_err(axi.bresp);

  // Only the first failing burst is recorded; a read wins a same-cycle tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      axi_err_o      <= 1'b0;
      axi_err_addr_o <= '0;
    end else if (!axi_err_o && (rd_err || wr_err)) begin
      axi_err_o      <= 1'b1;
      axi_err_addr_o <= rd_err ? r_addr_q : axi.awaddr;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{axi.rresp, axi.bresp};
`endif
endmodule

// File: tb/tb_ysyx_22041412_dcache_axi.sv
// Bench for the dcache AXI bridge: cache-side requesters and AXI slave responders as tasks.
module tb_ysyx_22041412_dcache_axi;
  import ysyx_22041412_axi_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk, rst;
  logic          r_valid_i;
  logic [AW-1:0] r_addr_i;
  logic [7:0]    r_len_i;
  logic          r_ready_o, r_last_o;
  logic [DW-1:0] r_data_o;
  logic          w_valid_i;
  logic [AW-1:0] w_addr_i;
  logic [2:0]    w_size_i;
  logic [7:0]    w_len_i;
  logic [DW-1:0] w_data_i;
  logic          w_ready_o, w_last_o;
  r_state_e      r_state_o;
  w_state_e      w_state_o;
`ifdef YSYX_22041412_AXI_ERR_CHK_EN
  logic          axi_err_o;
  logic [AW-1:0] axi_err_addr_o;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int b_hs_cyc = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_beats[$];

  ysyx_22041412_dcache_axi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  ysyx_22041412_dcache_axi dut (
    .clk(clk), .rst(rst),
    .r_valid_i(r_valid_i), .r_addr_i(r_addr_i), .r_len_i(r_len_i),
    .r_ready_o(r_ready_o), .r_last_o(r_last_o), .r_data_o(r_data_o),
    .w_valid_i(w_valid_i), .w_addr_i(w_addr_i), .w_size_i(w_size_i), .w_len_i(w_len_i),
    .w_data_i(w_data_i), .w_ready_o(w_ready_o), .w_last_o(w_last_o),
`ifdef YSYX_22041412_AXI_ERR_CHK_EN
    .axi_err_o(axi_err_o), .axi_err_addr_o(axi_err_addr_o),
`endif
    .r_state_o(r_state_o), .w_state_o(w_state_o),
    .axi(axi)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic drive_idle;
    r_valid_i = 0; r_addr_i = '0; r_len_i = '0;
    w_valid_i = 0; w_addr_i = '0; w_size_i = '0; w_len_i = '0; w_data_i = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = RESP_OKAY; axi.rlast = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = RESP_OKAY;
  endtask

  task automatic make_beats(input logic [7:0] len);
    wr_beats.delete();
    for (int i = 0; i <= int'(len); i++) wr_beats.push_back({$urandom, $urandom});
  endtask

  // AXI read responder: generates random beats and queues them as expected cache data.
  task automatic rd_slave(input logic [AW-1:0] addr, input logic [7:0] len,
                          input int ar_delay, input int gap_before, input int gap_len);
    int n, waited, i;
    bit done, fresh, gapped;
    logic [DW-1:0] d;
    n = 0; waited = 0; done = 0; d = '0;
    while (!done) begin
      @(negedge clk); #1;
      if (axi.arvalid) begin
        checks++;
        if (axi.araddr !== addr || axi.arlen !== len || axi.arsize !== SIZE_8B ||
            axi.arburst !== AXI_BURST_INCR) begin
          failures++;
          $display("FAIL ar_fields got addr=%h len=%0d size=%0d burst=%0d want addr=%h len=%0d",
                   axi.araddr, axi.arlen, axi.arsize, axi.arburst, addr, len);
        end
        if (n == ar_delay) begin axi.arready = 1; done = 1; end
        n++;
      end
      waited++;
      if (!done && waited > 200) begin
        failures++; $display("FAIL ar_timeout no arvalid for addr=%h", addr); return;
      end
    end
    @(negedge clk); axi.arready = 0;
    i = 0; fresh = 1; gapped = 0; waited = 0;
    while (i <= int'(len)) begin
      if (i == gap_before && !gapped) begin
        axi.rvalid = 0; repeat (gap_len) @(negedge clk); gapped = 1;
      end
      if (fresh) begin d = {$urandom, $urandom}; exp_q.push_back(d); fresh = 0; end
      axi.rvalid = 1; axi.rdata = d; axi.rresp = RESP_OKAY; axi.rlast = (i == int'(len));
      #1;
      checks++;
      if (axi.rready !== 1'b1) begin
        failures++; $display("FAIL rready got=%b want=1 beat=%0d", axi.rready, i);
      end else begin
        i++; fresh = 1;
      end
      @(negedge clk);
      waited++;
      if (waited > 600) begin
        failures++; $display("FAIL r_timeout beat=%0d", i);
        axi.rvalid = 0; axi.rlast = 0; return;
      end
    end
    axi.rvalid = 0; axi.rlast = 0;
  endtask

  // Cache read requester: checks every delivered beat against the responder's queue.
  task automatic cache_rd(input logic [AW-1:0] addr, input logic [7:0] len);
    int beats, waited;
    bit done, reissue;
    logic [DW-1:0] e;
    beats = 0; waited = 0; done = 0; reissue = 0;
    @(negedge clk); r_valid_i = 1; r_addr_i = addr; r_len_i = len;
    while (!done && waited < 800) begin
      @(negedge clk); #2;
      if (r_ready_o) begin
        beats++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if (r_data_o !== e) begin
          failures++; $display("FAIL rd_data beat=%0d got=%h want=%h", beats, r_data_o, e);
        end
        checks++;
        if (r_last_o !== (beats == int'(len) + 1)) begin
          failures++; $display("FAIL rd_last beat=%0d got=%b want=%b", beats, r_last_o,
                               (beats == int'(len) + 1));
        end
        if (r_last_o) done = 1;
      end
      waited++;
    end
    checks++;
    if (beats !== int'(len) + 1) begin
      failures++; $display("FAIL rd_beats got=%0d want=%0d", beats, int'(len) + 1);
    end
    repeat (6) begin
      @(negedge clk); r_valid_i = 0; #2;
      if (axi.arvalid || r_ready_o) reissue = 1;
    end
    checks++;
    if (reissue) begin failures++; $display("FAIL rd_reissue got=1 want=0"); end
  endtask

  // AXI write responder: checks AW fields, each W beat, then returns B with the given resp.
  task automatic wr_slave(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input int aw_delay, input logic [255:0] stall,
                          input logic [1:0] resp, input int b_delay);
    int n, waited, i;
    bit done, stalled, early_w;
    n = 0; waited = 0; done = 0; early_w = 0;
    while (!done) begin
      @(negedge clk); #1;
      if (axi.wvalid) early_w = 1;
      if (axi.awvalid) begin
        checks++;
        if (axi.awaddr !== addr || axi.awlen !== len || axi.awsize !== size ||
            axi.awburst !== AXI_BURST_INCR || axi.awid !== 4'd0) begin
          failures++;
          $display("FAIL aw_fields got addr=%h len=%0d size=%0d burst=%0d want addr=%h len=%0d size=%0d",
                   axi.awaddr, axi.awlen, axi.awsize, axi.awburst, addr, len, size);
        end
        if (n == aw_delay) begin axi.awready = 1; done = 1; end
        n++;
      end
      waited++;
      if (!done && waited > 200) begin
        failures++; $display("FAIL aw_timeout no awvalid for addr=%h", addr); return;
      end
    end
    checks++;
    if (early_w) begin failures++; $display("FAIL w_before_aw got wvalid=1 want=0"); end
    @(negedge clk); axi.awready = 0;
    i = 0; stalled = 0; waited = 0;
    while (i <= int'(len)) begin
      if (stall[i] && !stalled) begin axi.wready = 0; stalled = 1; end
      else axi.wready = 1;
      #1;
      if (axi.wvalid && axi.wready) begin
        checks++;
        if (axi.wdata !== wr_beats[i] || axi.wlast !== (i == int'(len)) || axi.wstrb !== 8'hFF) begin
          failures++;
          $display("FAIL w_beat idx=%0d got data=%h last=%b strb=%h want data=%h last=%b",
                   i, axi.wdata, axi.wlast, axi.wstrb, wr_beats[i], (i == int'(len)));
        end
        i++; stalled = 0;
      end
      @(negedge clk);
      waited++;
      if (waited > 800) begin
        failures++; $display("FAIL w_timeout beat=%0d", i); axi.wready = 0; return;
      end
    end
    axi.wready = 0;
    n = 0; waited = 0; done = 0;
    while (!done) begin
      #1;
      if (axi.bready) begin
        if (n == b_delay) begin
          axi.bvalid = 1; axi.bresp = resp; b_hs_cyc = cyc; done = 1;
        end
        n++;
      end
      @(negedge clk);
      waited++;
      if (!done && waited > 200) begin
        failures++; $display("FAIL b_timeout no bready"); return;
      end
    end
    axi.bvalid = 0; axi.bresp = RESP_OKAY;
  endtask

  // Cache write requester: presents beats from wr_beats, advancing after each w_ready_o.
  task automatic cache_wr(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size);
    int acc, last_cnt, last_cyc, waited, k;
    bit adv, reissue;
    acc = 0; last_cnt = 0; last_cyc = -1; waited = 0; k = 0; adv = 0; reissue = 0;
    @(negedge clk);
    w_valid_i = 1; w_addr_i = addr; w_len_i = len; w_size_i = size; w_data_i = wr_beats[0];
    while (last_cnt == 0 && waited < 900) begin
      @(negedge clk);
      if (adv) begin
        k++;
        if (k <= int'(len)) w_data_i = wr_beats[k];
        adv = 0;
      end
      #2;
      if (w_ready_o) begin acc++; adv = 1; end
      if (w_last_o) begin last_cnt++; last_cyc = cyc; end
      waited++;
    end
    repeat (6) begin
      @(negedge clk); w_valid_i = 0; #2;
      if (w_last_o) last_cnt++;
      if (axi.awvalid) reissue = 1;
    end
    checks++;
    if (acc !== int'(len) + 1) begin
      failures++; $display("FAIL wr_accepts got=%0d want=%0d", acc, int'(len) + 1);
    end
    checks++;
    if (last_cnt !== 1) begin failures++; $display("FAIL wr_last_pulses got=%0d want=1", last_cnt); end
    checks++;
    if (last_cyc !== b_hs_cyc + 1) begin
      failures++; $display("FAIL wr_last_timing got=%0d want=%0d", last_cyc, b_hs_cyc + 1);
    end
    checks++;
    if (reissue) begin failures++; $display("FAIL wr_reissue got=1 want=0"); end
  endtask

  task automatic test_reset;
    rst = 0; drive_idle();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({r_ready_o, r_last_o, w_ready_o, w_last_o, axi.arvalid, axi.rready,
         axi.awvalid, axi.wvalid, axi.bready} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outs got=%b want=0", {r_ready_o, r_last_o, w_ready_o, w_last_o,
               axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready});
    end
    checks++;
    if (r_state_o !== R_IDLE || w_state_o !== W_IDLE) begin
      failures++; $display("FAIL reset_state got r=%0d w=%0d want 0 0", r_state_o, w_state_o);
    end
    @(negedge clk); rst = 1;
    @(negedge clk);
  endtask

  task automatic test_read_len0;
    exp_q.delete();
    fork
      rd_slave(32'h8000_0000, 8'd0, 3, -1, 0);
      cache_rd(32'h8000_0000, 8'd0);
    join
  endtask

  task automatic test_read_gap;
    exp_q.delete();
    fork
      rd_slave(32'h8000_0040, 8'd3, 1, 1, 2);
      cache_rd(32'h8000_0040, 8'd3);
    join
  endtask

  task automatic test_write_stall;
    logic [255:0] m;
    m = '0; m[1] = 1'b1; m[4] = 1'b1;
    make_beats(8'd7);
    fork
      wr_slave(32'h8000_1000, 8'd7, SIZE_8B, 2, m, RESP_OKAY, 1);
      cache_wr(32'h8000_1000, 8'd7, SIZE_8B);
    join
  endtask

  task automatic test_concurrent;
    exp_q.delete();
    make_beats(8'd3);
    fork
      rd_slave(32'h8000_0100, 8'd3, 0, -1, 0);
      cache_rd(32'h8000_0100, 8'd3);
      wr_slave(32'h8000_0200, 8'd3, SIZE_8B, 0, '0, RESP_OKAY, 0);
      cache_wr(32'h8000_0200, 8'd3, SIZE_8B);
    join
  endtask

  task automatic test_len_max;
    logic [255:0] m;
    for (int j = 0; j < 8; j++) m[j*32 +: 32] = $urandom & $urandom;
    exp_q.delete();
    make_beats(8'd255);
    fork
      rd_slave(32'h8000_8000, 8'd255, 0, 100, 1);
      cache_rd(32'h8000_8000, 8'd255);
      wr_slave(32'h8000_9000, 8'd255, SIZE_8B, 1, m, RESP_OKAY, 2);
      cache_wr(32'h8000_9000, 8'd255, SIZE_8B);
    join
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++) begin
      logic [7:0]    rl, wl;
      logic [AW-1:0] ra, wa;
      logic [255:0]  m;
      int            mode;
      rl = 8'($urandom_range(0, 15));
      wl = 8'($urandom_range(0, 15));
      ra = 32'h8000_4000 | (32'($urandom_range(0, 255)) << 6);
      wa = 32'h8000_6000 | (32'($urandom_range(0, 255)) << 6);
      m = '0;
      m[31:0] = $urandom;
      mode = $urandom_range(0, 2);
      exp_q.delete();
      make_beats(wl);
      case (mode)
        0: fork
             rd_slave(ra, rl, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
             cache_rd(ra, rl);
           join
        1: fork
             wr_slave(wa, wl, SIZE_8B, $urandom_range(0, 3), m, RESP_OKAY, $urandom_range(0, 3));
             cache_wr(wa, wl, SIZE_8B);
           join
        default: fork
             rd_slave(ra, rl, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
             cache_rd(ra, rl);
             wr_slave(wa, wl, SIZE_8B, $urandom_range(0, 3), m, RESP_OKAY, $urandom_range(0, 3));
             cache_wr(wa, wl, SIZE_8B);
           join
      endcase
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    r_valid_i = 1; r_addr_i = 32'h8000_0500; r_len_i = 8'd3;
    w_valid_i = 1; w_addr_i = 32'h8000_0600; w_len_i = 8'd3; w_size_i = SIZE_8B;
    axi.arready = 1; axi.awready = 1;
    repeat (3) @(negedge clk);
    axi.arready = 0; axi.awready = 0; axi.rvalid = 1; axi.wready = 0;
    #1;
    checks++;
    if (axi.rready !== 1'b1 || axi.wvalid !== 1'b1 || r_ready_o !== 1'b1) begin
      failures++; $display("FAIL mid_setup got rready=%b wvalid=%b r_ready_o=%b want 1 1 1",
                           axi.rready, axi.wvalid, r_ready_o);
    end
    rst = 0;
    #1;
    checks++;
    if ({r_ready_o, r_last_o, w_ready_o, w_last_o, axi.arvalid, axi.rready,
         axi.awvalid, axi.wvalid, axi.bready} !== 9'b0) begin
      failures++;
      $display("FAIL mid_reset_outs got=%b want=0", {r_ready_o, r_last_o, w_ready_o, w_last_o,
               axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready});
    end
    checks++;
    if (r_state_o !== R_IDLE || w_state_o !== W_IDLE) begin
      failures++; $display("FAIL mid_reset_state got r=%0d w=%0d want 0 0", r_state_o, w_state_o);
    end
    drive_idle();
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (axi.arvalid !== 1'b0 || axi.awvalid !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle got ar=%b aw=%b want 0 0", axi.arvalid, axi.awvalid);
    end
  endtask

`ifdef YSYX_22041412_AXI_ERR_CHK_EN
  task automatic test_err;
    #1;
    checks++;
    if (axi_err_o !== 1'b0) begin failures++; $display("FAIL err_initial got=%b want=0", axi_err_o); end
    make_beats(8'd0);
    fork
      wr_slave(32'h8000_2000, 8'd0, SIZE_8B, 0, '0, RESP_SLVERR, 1);
      cache_wr(32'h8000_2000, 8'd0, SIZE_8B);
    join
    #1;
    checks++;
    if (axi_err_o !== 1'b1 || axi_err_addr_o !== 32'h8000_2000) begin
      failures++; $display("FAIL err_set got err=%b addr=%h want 1 80002000", axi_err_o, axi_err_addr_o);
    end
    make_beats(8'd1);
    fork
      wr_slave(32'h8000_3000, 8'd1, SIZE_8B, 0, '0, RESP_DECERR, 0);
      cache_wr(32'h8000_3000, 8'd1, SIZE_8B);
    join
    #1;
    checks++;
    if (axi_err_o !== 1'b1 || axi_err_addr_o !== 32'h8000_2000) begin
      failures++; $display("FAIL err_sticky got err=%b addr=%h want 1 80002000", axi_err_o, axi_err_addr_o);
    end
  endtask
`endif

  initial begin
    drive_idle();
    rst = 0;
    test_reset();
    test_read_len0();
    test_read_gap();
    test_write_stall();
    test_concurrent();
    test_len_max();
    test_random();
`ifdef YSYX_22041412_AXI_ERR_CHK_EN
    test_err();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
